// File: rtl/bp_error_accumulator_pkg.sv
// bp_pkg: shared definitions for the backprop error accumulator.
//   DATA_W / FRAC_W   default signed Q16.16 data format
//   MAX_FANOUT        largest number of contributions in one transaction
//   CNT_W             width of the fan-out count
//   ACC_W             internal accumulator width, wide enough that a full
//                     fan-out of extreme values cannot overflow it
//   bp_acc_state_t    accumulator FSM states
//   sat_to_data()     clamps a wide accumulator to DATA_W and flags clamping
package bp_pkg;

  localparam int DATA_W     = 32;
  localparam int FRAC_W     = 16;
  localparam int MAX_FANOUT = 32;
  localparam int CNT_W      = $clog2(MAX_FANOUT + 1);
  localparam int ACC_W      = DATA_W + CNT_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } bp_acc_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sat;
  } bp_sat_t;

  // The value fits in DATA_W exactly when every bit from the DATA_W sign
  // position upward matches; otherwise the top bit selects max or min.
  function automatic bp_sat_t sat_to_data(input logic [ACC_W-1:0] acc);
    bp_sat_t r;
    if ((acc[ACC_W-1:DATA_W-1] == '0) || (acc[ACC_W-1:DATA_W-1] == '1)) begin
      r.data = acc[DATA_W-1:0];
      r.sat  = 1'b0;
    end else if (!acc[ACC_W-1]) begin
      r.data = {1'b0, {(DATA_W-1){1'b1}}};
      r.sat  = 1'b1;
    end else begin
      r.data = {1'b1, {(DATA_W-1){1'b0}}};
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_error_accumulator_if.sv
// Handshake bundle between a contribution producer / result consumer and
// the error accumulator.
//   start, fanout          transaction request (fanout sampled with start)
//   in_valid/in_ready      contribution beat handshake, in_change payload
//   out_valid/out_ready    result handshake, out_error and out_sat payload
//   busy                   accumulator is not idle
// master: the producer/consumer side; slave: the accumulator.
interface bp_error_accumulator_if
  import bp_pkg::*;
  ();

  logic              start;
  logic [CNT_W-1:0]  fanout;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_change;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_error;
  logic              out_sat;
  logic              busy;

  modport master (
    output start, fanout, in_valid, in_change, out_ready,
    input  in_ready, out_valid, out_error, out_sat, busy
  );

  modport slave (
    input  start, fanout, in_valid, in_change, out_ready,
    output in_ready, out_valid, out_error, out_sat, busy
  );

endinterface

// File: rtl/bp_error_accumulator.sv
// bp_error_accumulator: sums a variable fan-out stream of signed backprop
// contributions into one saturated error value for the upstream neuron.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts any transaction
//   bus   slave side of bp_error_accumulator_if (request, beats, result)
//
// state | meaning
// IDLE  | waiting for start; no handshakes active
// ACCUM | accepting contributions until the latched count reaches zero
// DONE  | result held on out_error/out_sat until out_ready
module bp_error_accumulator
  import bp_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  bp_error_accumulator_if.slave  bus
);

  bp_acc_state_t     state_q;
  logic [CNT_W-1:0]  rem_q;
  logic [ACC_W-1:0]  acc_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] out_error_q;
  logic              out_sat_q;

  logic [CNT_W-1:0]  fanout_clamp;
  logic [ACC_W-1:0]  acc_d;
  bp_sat_t           sat_res;

  always_comb begin
    fanout_clamp = (bus.fanout > CNT_W'(MAX_FANOUT)) ? CNT_W'(MAX_FANOUT) : bus.fanout;
    acc_d        = acc_q + {{CNT_W{bus.in_change[DATA_W-1]}}, bus.in_change};
    sat_res      = sat_to_data(acc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_error_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rem_q  <= fanout_clamp;
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (fanout_clamp == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_error_q <= '0;
              out_sat_q   <= 1'b0;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q <= acc_d;
            rem_q <= rem_q - 1'b1;
            // Final beat: register the clamped result from the updated sum.
            if (rem_q == CNT_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_error_q <= sat_res.data;
              out_sat_q   <= sat_res.sat;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_error = out_error_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bp_error_accumulator.sv
// Self-checking bench for bp_error_accumulator. Expected results are pushed
// to a scoreboard when a transaction is driven and popped when the result
// handshake completes.
module tb_bp_error_accumulator;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_error_accumulator_if bus();

  bp_error_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] err;
    logic        sat;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned valid_rise = 0;
  exp_t        exp_q[$];
  logic [31:0] beats[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int fo);
    exp_t   e;
    longint s = 0;
    int     n = (fo > MAX_FANOUT) ? MAX_FANOUT : fo;
    for (int i = 0; i < n; i++) s += longint'($signed(beats[i]));
    if (s > 64'sd2147483647) begin
      e.err = 32'h7FFF_FFFF; e.sat = 1'b1;
    end else if (s < -64'sd2147483648) begin
      e.err = 32'h8000_0000; e.sat = 1'b1;
    end else begin
      e.err = s[31:0]; e.sat = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: compare on every completed result handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_error", bus.out_error, e.err);
        check("sb_sat", bus.out_sat, e.sat);
      end
    end
  end

  task automatic do_txn(input int fo, input bit gaps);
    exp_t e;
    bit   ok;
    int   n = (fo > MAX_FANOUT) ? MAX_FANOUT : fo;
    e = model(fo);
    exp_q.push_back(e);
    bus.fanout = CNT_W'(fo);
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    if (n == 0) begin
      check("zf_valid", bus.out_valid, 1);
      check("zf_in_ready", bus.in_ready, 0);
      valid_rise = cyc;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.in_valid  = 1'b1;
      bus.in_change = beats[i];
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (bus.in_ready) begin
          ok = 1'b1;
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) begin
        check("accept_timeout", 0, 1);
        return;
      end
    end
    check("latency_valid", bus.out_valid, 1);
    check("done_in_ready", bus.in_ready, 0);
    valid_rise = cyc;
  endtask

  task automatic wait_release();
    for (int k = 0; k < 50 && bus.out_valid; k++) begin
      @(posedge clk); #1;
    end
    if (bus.out_valid) check("release_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r1;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.fanout    = '0;
    bus.in_valid  = 1'b0;
    bus.in_change = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_error", bus.out_error, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sum
    beats = '{32'h0001_0000, 32'h0002_8000, 32'hFFFF_8000};
    do_txn(3, 0);
    check("basic_busy", bus.busy, 1);
    wait_release();

    // Zero fan-out
    beats = '{};
    do_txn(0, 0);
    wait_release();

    // Saturation both directions
    beats = '{32'h7FFF_0000, 32'h7FFF_0000};
    do_txn(2, 0);
    wait_release();
    beats = '{32'h8000_0000, 32'h8000_0000};
    do_txn(2, 0);
    wait_release();

    // Throughput with out_ready held high: N+2 cycles per transaction
    beats = '{32'h0000_0100, 32'hFFFF_FE00};
    do_txn(2, 0);
    r1 = valid_rise;
    wait_release();
    do_txn(2, 0);
    check("throughput", valid_rise - r1, 4);
    wait_release();

    // Backpressure in DONE with start and in_valid pulsed
    bus.out_ready = 1'b0;
    beats = '{32'h1234_5678};
    do_txn(1, 0);
    for (int i = 0; i < 5; i++) begin
      bus.start     = 1'b1;
      bus.fanout    = CNT_W'(3);
      bus.in_valid  = 1'b1;
      bus.in_change = 32'h0000_1111;
      @(posedge clk); #1;
      check("bp_valid", bus.out_valid, 1);
      check("bp_error", bus.out_error, 32'h1234_5678);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_busy", bus.busy, 1);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", bus.out_valid, 0);
    check("bp_idle", bus.busy, 0);

    // Reset mid-ACCUM, then a clean transaction
    bus.fanout = CNT_W'(4);
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_change = 32'h0001_0000;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    check("mid_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_in_ready", bus.in_ready, 0);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_out_error", bus.out_error, 0);
    check("mrst_out_sat", bus.out_sat, 0);
    check("mrst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    beats = '{32'h0001_0000};
    do_txn(1, 0);
    wait_release();

    // Fan-out clamp with random gaps
    beats = '{};
    for (int i = 0; i < 40; i++) beats.push_back(32'h0000_1000);
    do_txn(40, 1);
    wait_release();
    check("clamp_idle", bus.busy, 0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
